// File: rtl/change_dispenser_pkg.sv
// change_dispenser_pkg: FSM encoding and coin unit values (units of 5c) for the change dispenser
package change_dispenser_pkg;
  typedef enum logic [2:0] {IDLE, DEDUCT, SETTLE, VEND_DONE, RET_CHK, RET_WAIT} state_t;
  localparam int WIDTH_DEF = 6;
  localparam int PRICE_DEF = 13;
  localparam int U_QUARTER = 5;
  localparam int U_DIME    = 2;
  localparam int U_NICKEL  = 1;
endpackage

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: credit/request inputs and coin pulse outputs between dispenser and counter side
interface change_dispenser_if #(parameter int WIDTH = 6);
  logic [WIDTH-1:0] coin_count;
  logic select, coin_return;
  logic down_25, down_10, down_5;
  logic eject_q, eject_d, eject_n;
  logic vend, deny, coin_block;
  modport master (
    input  coin_count, select, coin_return,
    output down_25, down_10, down_5, eject_q, eject_d, eject_n, vend, deny, coin_block
  );
  modport slave (
    output coin_count, select, coin_return,
    input  down_25, down_10, down_5, eject_q, eject_d, eject_n, vend, deny, coin_block
  );
endinterface

// File: rtl/change_dispenser_coin_picker.sv
// coin_picker: greedy one-hot {quarter, dime, nickel} choice for a value in nickel units
module coin_picker
  import change_dispenser_pkg::*;
#(
  parameter int WIDTH = 6
) (
  input  logic [WIDTH-1:0] value_i,
  output logic [2:0]       pick_o
);
  always_comb
    pick_o = value_i >= WIDTH'(U_QUARTER) ? 3'b100 :
             value_i >= WIDTH'(U_DIME)    ? 3'b010 :
             value_i != '0                ? 3'b001 : 3'b000;
endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: deducts PRICE from the credit counter and vends, or greedily returns credit as coins.
// Define AUTO_CHANGE_EN to eject the remaining credit automatically after each vend.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PRICE = PRICE_DEF
) (
  input logic clk,
  input logic reset,
  change_dispenser_if.master bus
);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d, pick_v, pick_u;
  logic [2:0]       pick, dn_q, dn_d, ej_q, ej_d;
  logic             vend_q, vend_d, deny_q, deny_d, blk_q;

  // one shared picker: deduction walks the price, return walks the live credit
  assign pick_v = (state_q == DEDUCT) ? rem_q : bus.coin_count;
  coin_picker #(.WIDTH(WIDTH)) u_picker (.value_i(pick_v), .pick_o(pick));
  assign pick_u = pick[2] ? WIDTH'(U_QUARTER) : pick[1] ? WIDTH'(U_DIME) : pick[0] ? WIDTH'(U_NICKEL) : '0;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dn_d    = '0;
    ej_d    = '0;
    vend_d  = 1'b0;
    deny_d  = 1'b0;
    case (state_q)
      IDLE:
        if (bus.coin_return) state_d = RET_CHK;
        else if (bus.select) begin
          if (bus.coin_count >= WIDTH'(PRICE)) begin
            rem_d   = WIDTH'(PRICE);
            state_d = DEDUCT;
          end else deny_d = 1'b1;
        end
      DEDUCT: begin
        dn_d    = pick;
        rem_d   = rem_q - pick_u;
        state_d = (rem_d == '0) ? SETTLE : DEDUCT;
      end
      SETTLE: begin
        vend_d  = 1'b1;
        state_d = VEND_DONE;
      end
`ifdef AUTO_CHANGE_EN
      VEND_DONE: state_d = RET_CHK;
`else
      VEND_DONE: state_d = IDLE;
`endif
      RET_CHK:
        if (bus.coin_count == '0) state_d = IDLE;
        else begin
          dn_d    = pick;
          ej_d    = pick;
          state_d = RET_WAIT;
        end
      RET_WAIT: state_d = RET_CHK;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dn_q    <= '0;
      ej_q    <= '0;
      vend_q  <= 1'b0;
      deny_q  <= 1'b0;
      blk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dn_q    <= dn_d;
      ej_q    <= ej_d;
      vend_q  <= vend_d;
      deny_q  <= deny_d;
      blk_q   <= state_d != IDLE;
    end

  assign {bus.down_25, bus.down_10, bus.down_5} = dn_q;
  assign {bus.eject_q, bus.eject_d, bus.eject_n} = ej_q;
  assign bus.vend       = vend_q;
  assign bus.deny       = deny_q;
  assign bus.coin_block = blk_q;
endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench with a behavioural credit counter sharing clk/reset
module tb_change_dispenser;
  typedef struct {logic [7:0] pat; int cyc;} exp_t;
  localparam logic [7:0] P_Q = 8'h90, P_D = 8'h48, P_N = 8'h24;
  localparam logic [7:0] P_25 = 8'h80, P_10 = 8'h40, P_5 = 8'h20, P_VEND = 8'h02, P_DENY = 8'h01;

  logic clk = 1'b0, reset = 1'b1, ld = 1'b0;
  logic [5:0] ld_v = '0, cnt;
  int cyc = 0, chk = 0, err = 0, k;
  exp_t q[$];
  exp_t me;
  logic [7:0] outs;

  change_dispenser_if #(.WIDTH(6)) ifc ();
  change_dispenser #(.WIDTH(6), .PRICE(13)) dut (.clk(clk), .reset(reset), .bus(ifc));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (ld) cnt <= ld_v;
    else cnt <= cnt - (ifc.down_25 ? 6'd5 : ifc.down_10 ? 6'd2 : ifc.down_5 ? 6'd1 : 6'd0);
  assign ifc.coin_count = cnt;

  assign outs = {ifc.down_25, ifc.down_10, ifc.down_5, ifc.eject_q, ifc.eject_d, ifc.eject_n, ifc.vend, ifc.deny};

  task automatic check(input string nm, input int act, input int exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk)
    if (!reset && outs != 8'h00) begin
      if (q.size() == 0) begin
        chk++;
        err++;
        $display("FAIL unexpected output: got %b expected none (cycle %0d)", outs, cyc);
      end else begin
        me = q.pop_front();
        check("output pattern", int'(outs), int'(me.pat));
        check("output cycle", cyc, me.cyc);
      end
      if (|outs[7:5]) check("coin_block during down", int'(ifc.coin_block), 1);
      if (outs[0]) check("coin_block at deny", int'(ifc.coin_block), 0);
    end

  task automatic push(input logic [7:0] p, input int c);
    exp_t e;
    e.pat = p;
    e.cyc = c;
    q.push_back(e);
  endtask

  task automatic load(input logic [5:0] v);
    @(posedge clk); #1 ld = 1'b1; ld_v = v;
    @(posedge clk); #1 ld = 1'b0;
  endtask

  task automatic issue(input logic s, input logic r, output int kk);
    @(posedge clk); #1 ifc.select = s; ifc.coin_return = r; kk = cyc;
    @(posedge clk); #1 ifc.select = 1'b0; ifc.coin_return = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while ((q.size() != 0 || ifc.coin_block) && n < 80) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check({nm, " pending expectations"}, q.size(), 0);
    q.delete();
  endtask

  task automatic push_vend13(input int kk);
    push(P_25, kk + 2); push(P_25, kk + 3); push(P_10, kk + 4); push(P_5, kk + 5); push(P_VEND, kk + 6);
  endtask

  initial begin
    ifc.select = 1'b0;
    ifc.coin_return = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", int'(outs), 0);
    check("reset coin_block", int'(ifc.coin_block), 0);
    reset = 1'b0;
    @(negedge clk);
    check("reset count", int'(cnt), 0);

    // purchase with enough credit
    load(6'd20);
    issue(1'b1, 1'b0, k);
    push_vend13(k);
`ifdef AUTO_CHANGE_EN
    push(P_Q, k + 8); push(P_D, k + 10);
    wait_done("t1");
    check("t1 count", int'(cnt), 0);
`else
    wait_done("t1");
    check("t1 count", int'(cnt), 7);
`endif

    // insufficient credit
    load(6'd12);
    issue(1'b1, 1'b0, k);
    push(P_DENY, k + 1);
    wait_done("t2");
    check("t2 count", int'(cnt), 12);
    check("t2 coin_block", int'(ifc.coin_block), 0);

    // coin return
    load(6'd8);
    issue(1'b0, 1'b1, k);
    push(P_Q, k + 2); push(P_D, k + 4); push(P_N, k + 6);
    wait_done("t3");
    check("t3 count", int'(cnt), 0);

    // change after vend
    load(6'd16);
    issue(1'b1, 1'b0, k);
    push_vend13(k);
`ifdef AUTO_CHANGE_EN
    push(P_D, k + 8); push(P_N, k + 10);
    wait_done("t4");
    check("t4 count", int'(cnt), 0);
`else
    wait_done("t4");
    check("t4 count", int'(cnt), 3);
`endif

    // select and return together: return wins
    load(6'd20);
    issue(1'b1, 1'b1, k);
    for (int i = 0; i < 4; i++) push(P_Q, k + 2 + 2 * i);
    wait_done("t5");
    check("t5 count", int'(cnt), 0);

    // async reset mid-deduction
    load(6'd20);
    issue(1'b1, 1'b0, k);
    push(P_25, k + 2); push(P_25, k + 3);
    do @(negedge clk); while (cyc < k + 3);
    #1 reset = 1'b1;
    #1;
    check("t6 outputs in reset", int'(outs), 0);
    check("t6 coin_block in reset", int'(ifc.coin_block), 0);
    check("t6 count in reset", int'(cnt), 0);
    check("t6 pulses seen", q.size(), 0);
    q.delete();
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b0;
    issue(1'b1, 1'b0, k);
    push(P_DENY, k + 1);
    wait_done("t6");
    check("t6 count after", int'(cnt), 0);

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
